// File: rtl/sram_rr_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port SRAM.
// Registers one command per cycle onto the SRAM pins and tags read returns.
module sram_rr_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_din,
    input  logic              p0_lock,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_din,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t state;
    logic   last_gnt;
    logic   g0;
    logic   g1;
    logic   t1_v;
    logic   t1_p;
    logic   t2_v;
    logic   t2_p;

    // Grant decode: owner-only while locked, otherwise round-robin on ties
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        unique case (state)
            OWN0: g0 = p0_req;
            OWN1: g1 = p1_req;
            default: begin
                if (p0_req && p1_req) begin
                    g0 = last_gnt;
                    g1 = !last_gnt;
                end else begin
                    g0 = p0_req;
                    g1 = p1_req;
                end
            end
        endcase
    end

    assign p0_gnt = g0;
    assign p1_gnt = g1;

    // Lock ownership state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                OWN0: if (!p0_lock) state <= IDLE;
                OWN1: if (!p1_lock) state <= IDLE;
                default: begin
                    if (g0 && p0_lock)
                        state <= OWN0;
                    else if (g1 && p1_lock)
                        state <= OWN1;
                end
            endcase
        end
    end

    // Remember which port was granted last; 1 lets port 0 win the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_gnt <= 1'b1;
        else if (g0 || g1)
            last_gnt <= g1;
    end

    // Register the granted command onto the SRAM pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (g0) begin
            mem_we   <= p0_we;
            mem_addr <= p0_addr;
            mem_din  <= p0_din;
        end else if (g1) begin
            mem_we   <= p1_we;
            mem_addr <= p1_addr;
            mem_din  <= p1_din;
        end else begin
            mem_we <= 1'b0;
        end
    end

    // Two-stage read tag pipeline aligning the port id with mem_dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1_v <= 1'b0;
            t1_p <= 1'b0;
            t2_v <= 1'b0;
            t2_p <= 1'b0;
        end else begin
            t1_v <= (g0 && !p0_we) || (g1 && !p1_we);
            t1_p <= g1;
            t2_v <= t1_v;
            t2_p <= t1_p;
        end
    end

    assign p0_rvalid = t2_v && !t2_p;
    assign p1_rvalid = t2_v && t2_p;
    assign rdata     = mem_dout;

endmodule
